// File: rtl/shift_load_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : shift_load_ctrl
//  Purpose  : Sequencer for a WIDTH-bit parallel-in shift register. It accepts
//             parallel words over a valid/ready handshake into a one-entry
//             holding buffer. For each word it drives a one-cycle load strobe
//             and then exactly WIDTH shift cycles. After the final shift it
//             pulses DONE. An optional run of idle cycles (GAP) can follow
//             each word.
//  Ports    : CLK, RST       - clock (rising edge), synchronous active-high reset
//             IN_DATA/VALID  - word to serialise and its valid flag
//             IN_READY       - holding buffer empty (accept = VALID & READY)
//             SI_FILL        - value presented on SI during shift cycles
//             D, L, SH, SI   - register parallel data, load, shift, serial-in
//             BUSY, DONE     - FSM not idle / one-cycle end-of-word pulse
//             ABORT          - (only with SHIFT_LOAD_CTRL_ABORT_EN) stop the
//                              current word and return to IDLE
//  Options  : define SHIFT_LOAD_CTRL_ABORT_EN to add the ABORT input
//  Revision : 1.0 - initial release
// ============================================================================
module shift_load_ctrl #(
  parameter int WIDTH = 4,
  parameter int GAP   = 0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] IN_DATA,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic             SI_FILL,
`ifdef SHIFT_LOAD_CTRL_ABORT_EN
  input  logic             ABORT,
`endif
  output logic [WIDTH-1:0] D,
  output logic             L,
  output logic             SH,
  output logic             SI,
  output logic             BUSY,
  output logic             DONE
);

  localparam int             CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);
  localparam logic [3:0]     GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0]       gap_q, gap_d;
  logic             buf_full_q, buf_full_d;
  logic [WIDTH-1:0] buf_q;

  logic             in_ready_q;
  logic [WIDTH-1:0] d_q;
  logic             l_q, sh_q, si_q, busy_q, done_q;

  logic             accept;
  logic             free_buf;
  logic             last_shift;
  logic             abort_w;

`ifdef SHIFT_LOAD_CTRL_ABORT_EN
  // Abort is ignored while idle so a stray pulse cannot disturb the buffer.
  assign abort_w = ABORT & (state_q != S_IDLE);
`else
  assign abort_w = 1'b0;
`endif

  assign accept     = IN_VALID & in_ready_q;
  assign last_shift = (state_q == S_SHIFT) && (cnt_q == LAST_CNT);
  // The buffered word moves into the register path on the edge the FSM
  // enters LOAD; that same edge empties the buffer.
  assign free_buf   = (state_d == S_LOAD) && (state_q != S_LOAD);
  // A new word arriving on the freeing edge keeps the buffer full.
  assign buf_full_d = accept | (buf_full_q & ~free_buf);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    case (state_q)
      S_IDLE: begin
        if (buf_full_q) state_d = S_LOAD;
      end
      S_LOAD: begin
        state_d = S_SHIFT;
        cnt_d   = '0;
      end
      S_SHIFT: begin
        if (last_shift) begin
          cnt_d = '0;
          if (GAP > 0) begin
            state_d = S_GAP;
            gap_d   = 4'd0;
          end else if (buf_full_q) begin
            state_d = S_LOAD;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d   = 4'd0;
          state_d = buf_full_q ? S_LOAD : S_IDLE;
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (abort_w) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      gap_d   = 4'd0;
    end
  end

  // Outputs are decoded from the next state, so each output cycle lines up
  // with the FSM state that produced it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      gap_q      <= 4'd0;
      buf_full_q <= 1'b0;
      buf_q      <= '0;
      in_ready_q <= 1'b1;
      d_q        <= '0;
      l_q        <= 1'b0;
      sh_q       <= 1'b0;
      si_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gap_q      <= gap_d;
      buf_full_q <= buf_full_d;
      if (accept) buf_q <= IN_DATA;
      in_ready_q <= ~buf_full_d;
      if (free_buf) d_q <= buf_q;
      l_q        <= (state_d == S_LOAD);
      sh_q       <= (state_d == S_SHIFT);
      si_q       <= (state_d == S_SHIFT) & SI_FILL;
      busy_q     <= (state_d != S_IDLE);
      done_q     <= last_shift & ~abort_w;
    end
  end

  assign IN_READY = in_ready_q;
  assign D        = d_q;
  assign L        = l_q;
  assign SH       = sh_q;
  assign SI       = si_q;
  assign BUSY     = busy_q;
  assign DONE     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_load_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_shift_load_ctrl
//  Purpose  : Self-checking bench for shift_load_ctrl (WIDTH=4). A cycle table
//             covers reset, single word, back-to-back, SI fill and mid-shift
//             reset; a second instance with GAP=3 and an optional abort
//             sequence are checked by hand-written sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_shift_load_ctrl;

  logic       clk = 1'b0;
  logic       rst, vld, sif, abort_s;
  logic [3:0] dat;
  logic       rdy, l, sh, si, busy, done;
  logic [3:0] d;

  logic       vld2;
  logic [3:0] dat2;
  logic       rdy2, l2, sh2, si2, busy2, done2;
  logic [3:0] d2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shift_load_ctrl #(.WIDTH(4), .GAP(0)) u_dut (
    .CLK(clk), .RST(rst), .IN_DATA(dat), .IN_VALID(vld), .IN_READY(rdy),
    .SI_FILL(sif),
`ifdef SHIFT_LOAD_CTRL_ABORT_EN
    .ABORT(abort_s),
`endif
    .D(d), .L(l), .SH(sh), .SI(si), .BUSY(busy), .DONE(done)
  );

  shift_load_ctrl #(.WIDTH(4), .GAP(3)) u_gap (
    .CLK(clk), .RST(rst), .IN_DATA(dat2), .IN_VALID(vld2), .IN_READY(rdy2),
    .SI_FILL(sif),
`ifdef SHIFT_LOAD_CTRL_ABORT_EN
    .ABORT(1'b0),
`endif
    .D(d2), .L(l2), .SH(sh2), .SI(si2), .BUSY(busy2), .DONE(done2)
  );

  // Model of the attached 4-bit parallel-in shift register.
  logic [3:0] sreg = 4'h0;
  always @(posedge clk) begin
    if (l)       sreg <= d;
    else if (sh) sreg <= {sreg[2:0], si};
  end

  typedef struct {
    logic       rst, vld;
    logic [3:0] dat;
    logic       sif;
    logic       rdy, l, sh, si, busy, done;
    logic [3:0] d;
  } vec_t;

  vec_t tbl[47];

  task automatic chk(input string name, input int row, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0h want %0h", name, row, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [3:0] dd,
                      input logic s);
    rst = r; vld = v; dat = dd; sif = s;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic r, input logic v, input logic [3:0] dd,
                              input logic s, input logic e_rdy, input logic e_l,
                              input logic e_sh, input logic e_si,
                              input logic e_busy, input logic e_done,
                              input logic [3:0] e_d);
    vec_t t;
    t.rst = r; t.vld = v; t.dat = dd; t.sif = s;
    t.rdy = e_rdy; t.l = e_l; t.sh = e_sh; t.si = e_si;
    t.busy = e_busy; t.done = e_done; t.d = e_d;
    return t;
  endfunction

  int         l_at[$];
  int         sh_at[$];
  int         dn_cnt;
  int         wi;
  int         last_sh;
  logic [3:0] l2_d;
  logic [3:0] w0, w1;
  logic       acc;
  int         ab_sh, ab_dn;

  initial begin
    rst = 1'b1; vld = 1'b0; dat = 4'h0; sif = 1'b0; abort_s = 1'b0;
    vld2 = 1'b0; dat2 = 4'h0;

    //              rst vld dat  sif | rdy l sh si busy done d
    // single word 4'hB
    tbl[0]  = mk(1, 0, 4'h0, 0,  1, 0, 0, 0, 0, 0, 4'h0);
    tbl[1]  = mk(0, 1, 4'hB, 0,  0, 0, 0, 0, 0, 0, 4'h0);
    tbl[2]  = mk(0, 0, 4'h0, 0,  1, 1, 0, 0, 1, 0, 4'hB);
    tbl[3]  = mk(0, 0, 4'h0, 0,  1, 0, 1, 0, 1, 0, 4'hB);
    tbl[4]  = mk(0, 0, 4'h0, 0,  1, 0, 1, 0, 1, 0, 4'hB);
    tbl[5]  = mk(0, 0, 4'h0, 0,  1, 0, 1, 0, 1, 0, 4'hB);
    tbl[6]  = mk(0, 0, 4'h0, 0,  1, 0, 1, 0, 1, 0, 4'hB);
    tbl[7]  = mk(0, 0, 4'h0, 0,  1, 0, 0, 0, 0, 1, 4'hB);
    tbl[8]  = mk(0, 0, 4'h0, 0,  1, 0, 0, 0, 0, 0, 4'hB);
    // back-to-back 4'hA then 4'h5, valid held
    tbl[9]  = mk(0, 1, 4'hA, 0,  0, 0, 0, 0, 0, 0, 4'hB);
    tbl[10] = mk(0, 1, 4'h5, 0,  1, 1, 0, 0, 1, 0, 4'hA);
    tbl[11] = mk(0, 1, 4'h5, 0,  0, 0, 1, 0, 1, 0, 4'hA);
    tbl[12] = mk(0, 0, 4'h0, 0,  0, 0, 1, 0, 1, 0, 4'hA);
    tbl[13] = mk(0, 0, 4'h0, 0,  0, 0, 1, 0, 1, 0, 4'hA);
    tbl[14] = mk(0, 0, 4'h0, 0,  0, 0, 1, 0, 1, 0, 4'hA);
    tbl[15] = mk(0, 0, 4'h0, 0,  1, 1, 0, 0, 1, 1, 4'h5);
    tbl[16] = mk(0, 0, 4'h0, 0,  1, 0, 1, 0, 1, 0, 4'h5);
    tbl[17] = mk(0, 0, 4'h0, 0,  1, 0, 1, 0, 1, 0, 4'h5);
    tbl[18] = mk(0, 0, 4'h0, 0,  1, 0, 1, 0, 1, 0, 4'h5);
    tbl[19] = mk(0, 0, 4'h0, 0,  1, 0, 1, 0, 1, 0, 4'h5);
    tbl[20] = mk(0, 0, 4'h0, 0,  1, 0, 0, 0, 0, 1, 4'h5);
    tbl[21] = mk(0, 0, 4'h0, 0,  1, 0, 0, 0, 0, 0, 4'h5);
    // SI_FILL=1 word 4'h6
    tbl[22] = mk(0, 1, 4'h6, 1,  0, 0, 0, 0, 0, 0, 4'h5);
    tbl[23] = mk(0, 0, 4'h0, 1,  1, 1, 0, 0, 1, 0, 4'h6);
    tbl[24] = mk(0, 0, 4'h0, 1,  1, 0, 1, 1, 1, 0, 4'h6);
    tbl[25] = mk(0, 0, 4'h0, 1,  1, 0, 1, 1, 1, 0, 4'h6);
    tbl[26] = mk(0, 0, 4'h0, 1,  1, 0, 1, 1, 1, 0, 4'h6);
    tbl[27] = mk(0, 0, 4'h0, 1,  1, 0, 1, 1, 1, 0, 4'h6);
    tbl[28] = mk(0, 0, 4'h0, 1,  1, 0, 0, 0, 0, 1, 4'h6);
    tbl[29] = mk(0, 0, 4'h0, 0,  1, 0, 0, 0, 0, 0, 4'h6);
    // mid-shift reset with 4'hC buffered
    tbl[30] = mk(0, 1, 4'h9, 0,  0, 0, 0, 0, 0, 0, 4'h6);
    tbl[31] = mk(0, 1, 4'hC, 0,  1, 1, 0, 0, 1, 0, 4'h9);
    tbl[32] = mk(0, 1, 4'hC, 0,  0, 0, 1, 0, 1, 0, 4'h9);
    tbl[33] = mk(0, 0, 4'h0, 0,  0, 0, 1, 0, 1, 0, 4'h9);
    tbl[34] = mk(1, 0, 4'h0, 0,  1, 0, 0, 0, 0, 0, 4'h0);
    tbl[35] = mk(0, 0, 4'h0, 0,  1, 0, 0, 0, 0, 0, 4'h0);
    tbl[36] = mk(0, 0, 4'h0, 0,  1, 0, 0, 0, 0, 0, 4'h0);
    tbl[37] = mk(0, 0, 4'h0, 0,  1, 0, 0, 0, 0, 0, 4'h0);
    tbl[38] = mk(0, 0, 4'h0, 0,  1, 0, 0, 0, 0, 0, 4'h0);
    tbl[39] = mk(0, 1, 4'h7, 0,  0, 0, 0, 0, 0, 0, 4'h0);
    tbl[40] = mk(0, 0, 4'h0, 0,  1, 1, 0, 0, 1, 0, 4'h7);
    tbl[41] = mk(0, 0, 4'h0, 0,  1, 0, 1, 0, 1, 0, 4'h7);
    tbl[42] = mk(0, 0, 4'h0, 0,  1, 0, 1, 0, 1, 0, 4'h7);
    tbl[43] = mk(0, 0, 4'h0, 0,  1, 0, 1, 0, 1, 0, 4'h7);
    tbl[44] = mk(0, 0, 4'h0, 0,  1, 0, 1, 0, 1, 0, 4'h7);
    tbl[45] = mk(0, 0, 4'h0, 0,  1, 0, 0, 0, 0, 1, 4'h7);
    tbl[46] = mk(0, 0, 4'h0, 0,  1, 0, 0, 0, 0, 0, 4'h7);

    for (int i = 0; i < 47; i++) begin
      step(tbl[i].rst, tbl[i].vld, tbl[i].dat, tbl[i].sif);
      chk("IN_READY", i, {31'd0, rdy},  {31'd0, tbl[i].rdy});
      chk("L",        i, {31'd0, l},    {31'd0, tbl[i].l});
      chk("SH",       i, {31'd0, sh},   {31'd0, tbl[i].sh});
      chk("SI",       i, {31'd0, si},   {31'd0, tbl[i].si});
      chk("BUSY",     i, {31'd0, busy}, {31'd0, tbl[i].busy});
      chk("DONE",     i, {31'd0, done}, {31'd0, tbl[i].done});
      chk("D",        i, {28'd0, d},    {28'd0, tbl[i].d});
      if (i == 28) chk("sreg_after_fill", i, {28'd0, sreg}, 32'h0000000F);
    end

    // GAP=3 instance: two queued words.
    w0 = 4'h1; w1 = 4'h2;
    wi = 0; dn_cnt = 0; l2_d = 4'h0;
    vld2 = 1'b1; dat2 = w0;
    for (int c = 0; c < 40; c++) begin
      acc = vld2 & rdy2;
      @(posedge clk);
      #1;
      if (acc) begin
        wi++;
        if (wi == 1) dat2 = w1;
        else vld2 = 1'b0;
      end
      if (l2) begin
        l_at.push_back(c);
        l2_d = d2;
      end
      if (sh2) sh_at.push_back(c);
      if (done2) dn_cnt++;
    end
    chk("gap_load_count", 100, l_at.size(), 2);
    chk("gap_shift_count", 101, sh_at.size(), 8);
    chk("gap_done_count", 102, dn_cnt, 2);
    if (l_at.size() == 2 && sh_at.size() >= 4) begin
      last_sh = sh_at[3];
      chk("gap_first_span", 103, last_sh - l_at[0], 4);
      chk("gap_idle_cycles", 104, l_at[1] - last_sh - 1, 3);
      chk("gap_second_d", 105, {28'd0, l2_d}, {28'd0, w1});
    end else begin
      chk("gap_timeline", 106, l_at.size(), 2);
    end

`ifdef SHIFT_LOAD_CTRL_ABORT_EN
    step(0, 1, 4'hE, 0);
    step(0, 1, 4'h3, 0);
    chk("ab_load_d", 200, {28'd0, d}, 32'hE);
    step(0, 1, 4'h3, 0);
    step(0, 0, 4'h0, 0);
    step(0, 0, 4'h0, 0);
    chk("ab_sh3", 201, {31'd0, sh}, 1);
    abort_s = 1'b1;
    step(0, 0, 4'h0, 0);
    abort_s = 1'b0;
    chk("ab_sh_off", 202, {31'd0, sh}, 0);
    chk("ab_l_off", 203, {31'd0, l}, 0);
    chk("ab_no_done", 204, {31'd0, done}, 0);
    step(0, 0, 4'h0, 0);
    chk("ab_next_l", 205, {31'd0, l}, 1);
    chk("ab_next_d", 206, {28'd0, d}, 32'h3);
    ab_sh = 0; ab_dn = 0;
    for (int c = 0; c < 10; c++) begin
      step(0, 0, 4'h0, 0);
      if (sh) ab_sh++;
      if (done) ab_dn++;
    end
    chk("ab_shifts", 207, ab_sh, 4);
    chk("ab_done", 208, ab_dn, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/shift_load_ctrl.md
Name: shift_load_ctrl

Overview:
- Sequencer that sits directly upstream of the 4-bit parallel-in shift register.
- Accepts parallel words over a valid/ready handshake and buffers one word.
- Drives the register's D, L, SH and SI pins: a 1-cycle load pulse, then exactly WIDTH shift cycles per word.
- Pulses DONE when a word has been fully shifted; optional inter-word gap.

Parameters:
- WIDTH, 4, word width; equals the downstream register length. Legal range 2..16.
- GAP, 0, idle cycles inserted after each word's final shift. Legal range 0..15.

Ports:
- CLK  in  1  clock; all logic on the rising edge.
- RST  in  1  synchronous reset, active-high.
- IN_DATA  in  WIDTH  word to serialise.
- IN_VALID  in  1  IN_DATA valid.
- IN_READY  out  1  holding buffer empty; a word is accepted on an edge where IN_VALID and IN_READY are both 1.
- SI_FILL  in  1  value driven on SI during shift cycles.
- D  out  WIDTH  parallel load data to the register; D[0] maps to D0.
- L  out  1  load strobe to the register.
- SH  out  1  shift enable to the register.
- SI  out  1  serial-in to the register.
- BUSY  out  1  state is not IDLE.
- DONE  out  1  1-cycle pulse after a word's final shift.

Behaviour:
- All outputs registered. Reset values:
  - IN_READY=1; D=0, L=0, SH=0, SI=0, BUSY=0, DONE=0.
  - Holding buffer empty, state IDLE, counters 0.
- Holding buffer (one entry):
  - IN_READY = !buf_full.
  - An accept loads the buffer; buf_full=1 from the next cycle.
  - Buffer is freed in the cycle the FSM enters LOAD.
  - Accept and free on the same edge: the buffer stays full with the new word; no loss, no duplication.
- FSM states: IDLE, LOAD, SHIFT, GAP.
- IDLE:
  - L=SH=0.
  - If buf_full -> LOAD on the next edge. A word accepted at edge t gives L=1 during cycle t+2.
- LOAD (exactly 1 cycle):
  - L=1, SH=0, D=buffered word.
  - -> SHIFT.
- SHIFT (exactly WIDTH cycles):
  - SH=1, L=0, SI=SI_FILL.
  - Counter runs 0..WIDTH-1.
  - On the last count: if GAP>0 -> GAP; else if buf_full -> LOAD; else -> IDLE.
  - L and SH are never high in the same cycle.
- DONE is high for exactly 1 cycle: the cycle immediately after the final SH=1 cycle.
- GAP (GAP cycles):
  - L=SH=0.
  - Then -> LOAD if buf_full, else -> IDLE.
- Back-to-back with GAP=0: final SH cycle is followed directly by the LOAD cycle. Per word the cadence is 1 L cycle plus WIDTH SH cycles, with no bubble.
- D holds its last loaded value outside LOAD. SI=0 outside SHIFT.
- RST asserted mid-word:
  - On the next edge everything returns to reset values and the buffered word is discarded.
  - No DONE pulse.
- IN_VALID while IN_READY=0: the word is ignored; the producer must hold it.
- IN_DATA is sampled only on the accept edge.

Optional Feature:
- Macro: SHIFT_LOAD_CTRL_ABORT_EN.
- With the macro defined:
  - Extra port ABORT (in, 1).
  - ABORT=1 in LOAD, SHIFT or GAP -> IDLE on the next edge, with L=SH=0 from that cycle.
  - No DONE for the aborted word; the holding buffer is kept, so a buffered word starts normally afterwards.
  - ABORT in IDLE has no effect.
  - If ABORT coincides with the final SHIFT cycle, the abort wins and DONE is suppressed.
- Without the macro: no ABORT port, and every started word always completes.

Test Plan:
- Reset, then single word (WIDTH=4, GAP=0, SI_FILL=0):
  - Accept 4'b1011 at edge t -> L=1, D=4'b1011 in cycle t+2.
  - SH=1 in cycles t+3..t+6; DONE=1 in cycle t+7; BUSY falls with DONE.
- Back-to-back, GAP=0:
  - Offer 4'hA then 4'h5 with IN_VALID held.
  - Second accept happens while the first word is in LOAD; IN_READY=0 until the second word's LOAD.
  - Second L=1 in the cycle right after the first word's 4th SH cycle.
  - Two DONE pulses, 5 cycles apart.
- GAP=3:
  - Two queued words give exactly 3 cycles of L=SH=0 between the first word's last SH and the second word's L.
- Mid-shift reset:
  - Assert RST during the 2nd SH cycle with a word buffered.
  - Next cycle: all outputs at reset values, IN_READY=1, no DONE; subsequent L only after a new accept.
- SI_FILL=1 during shifts:
  - SI=1 exactly in the SH cycles and 0 otherwise.
  - With the shift register attached, after 4 shifts Q0..Q3 = 1111.
- ABORT (macro defined):
  - ABORT at the 3rd SH cycle -> SH=0 next cycle and no DONE.
  - The buffered word 4'h3 then produces L with D=4'h3 and completes with DONE.
